dsp_preadd_mult_stage: RTL and testbench
========================================

// Module: dsp_preadd_mult_stage
// PURPOSE
// - Stage directly downstream of the D/B/A input register muxes in the DSP48A1 slice model.
// - Forms pre-adder result B1 = D +/- B0 (or bypass B0), optionally registers it (B1REG).
// - Multiplies B1 by A1 (18x18 signed) and optionally registers the product (MREG).
// - Carries a valid bit alongside the data so the downstream post-adder knows when M is meaningful.
// - Also drives BCOUT for cascade.
// PARAMETERS
// - WIDTH      18   operand width of A, B, D (signed two's complement)
// - B1REG      1    0: B1 path combinational; 1: B1 registered (clock enable ceb1)
// - MREG       1    0: M path combinational; 1: M registered (clock enable cem)
// PORTS
// - clk        in   1         rising-edge clock
// - rst        in   1         async active-low reset, clears every register in this block
// - ceb1       in   1         clock enable for B1 register and its valid bit
// - cem        in   1         clock enable for M register and its valid bit
// - in_valid   in   1         d0/b0/a1 are valid this cycle (from upstream register stage)
// - opmode     in   2         [0] preadd_en (OPMODE[4]); [1] preadd_sub (OPMODE[6])
// - d0         in   WIDTH     D operand after upstream D register mux
// - b0         in   WIDTH     B operand after upstream B0 register mux
// - a1         in   WIDTH     A operand after upstream A1 register mux
// - bcout      out  WIDTH     B1 value (registered or not per B1REG), cascade output
// - m          out  2*WIDTH   signed product B1*A1
// - m_valid    out  1         m holds the product of a valid input sample
// BEHAVIOUR
// - Async active-low reset: when rst==0, immediately b1_reg=0, m_reg=0, valid bits=0;
//   thus bcout=0 (if B1REG), m=0 (if MREG), m_valid=0 (if any reg stage); holds while rst low.
// - Pre-adder (combinational):
//   - preadd_en=0 -> pre = b0
//   - preadd_en=1, sub=0 -> pre = d0 + b0
//   - preadd_en=1, sub=1 -> pre = d0 - b0
//   - Result truncated to WIDTH bits (wraps mod 2^WIDTH, no saturation, no carry out).
//   - preadd_sub ignored when preadd_en=0.
// - B1 stage: B1REG=1 -> b1_reg <= pre and v1 <= in_valid on posedge clk when ceb1=1,
//   else hold; B1REG=0 -> b1=pre, v1=in_valid combinationally. bcout = b1.
// - Multiplier: prod = signed(b1) * signed(a1), full 2*WIDTH result, never overflows.
//   a1 is NOT delayed here; upstream aligns A1 with B1 timing.
// - M stage: MREG=1 -> m_reg <= prod, vm <= v1 when cem=1, else hold; MREG=0 -> pass-through.
// - Latency in_valid->m_valid = B1REG + MREG cycles with enables held high (0, 1 or 2).
// - Enable low freezes that stage (data and valid together); no bubbles inserted, no samples dropped.
// - Simultaneous ceb1=1 & cem=1: M captures the OLD b1_reg product (normal pipeline shift).
// - Reset release mid-stream: first m_valid only after a fresh in_valid propagates.
// - Invalid samples still flow through data path; only valid bit marks them.
// STRUCTURE
// - Shared package dsp48a1_pkg: WIDTH default, OPMODE bit indices (PREADD_EN=4, PREADD_SUB=6),
//   localparam for product width 2*WIDTH.
// - One sub-module: dsp_pipe_reg (params REG, W; ports clk, rst, ce, d, q), async active-low clear;
//   instantiated for b1 (W=WIDTH+1, data+valid) and m (W=2*WIDTH+1).
// - Top: pre-adder mux, signed multiplier, two dsp_pipe_reg instances.
// TESTING
// - Reset: drive rst=0 with nonzero inputs -> bcout=0, m=0, m_valid=0 immediately, no clk needed.
// - Add: B1REG=MREG=1, d0=5, b0=3, a1=-2, preadd_en=1, sub=0, valid -> bcout=8 after 1 clk,
//   m=-16, m_valid=1 after 2 clk.
// - Subtract+wrap: d0=-131072, b0=1, sub=1 -> bcout=131071 (wrap); a1=2 -> m=262142.
// - Bypass: preadd_en=0, sub=1, b0=-7, a1=-7 -> bcout=-7, m=49; sub bit has no effect.
// - Stall: back-to-back valid samples, drop cem for 3 clk -> m/m_valid frozen, no sample lost,
//   output order matches input order once cem returns.
// - Param sweep: B1REG/MREG in {0,1}^2 -> m_valid latency 0/1/1/2; full-scale
//   -131072*-131072 = 17179869184 exact.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: shared widths and OPMODE bit positions for the DSP48A1 slice model.
// OPMODE_PREADD_EN / OPMODE_PREADD_SUB are the slice-level OPMODE bits; the stage
// receives them as a 2-bit field, with OP_EN / OP_SUB giving their local positions.
package dsp48a1_pkg;
  localparam int DSP_WIDTH = 18;
  localparam int DSP_PROD_W = 2 * DSP_WIDTH;
  localparam int OPMODE_PREADD_EN = 4;
  localparam int OPMODE_PREADD_SUB = 6;
  // the local field packs OPMODE[4] and OPMODE[6] into bits 0 and 1
  localparam int OP_EN = (OPMODE_PREADD_EN - 4) / 2;
  localparam int OP_SUB = (OPMODE_PREADD_SUB - 4) / 2;
endpackage

// File: rtl/dsp_preadd_mult_stage_if.sv
// dsp_preadd_mult_stage_if: operand/control bundle into the pre-adder/multiplier stage and its results out.
// master drives ceb1, cem, in_valid, opmode, d0, b0, a1; slave drives bcout, m, m_valid.
interface dsp_preadd_mult_stage_if
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH = DSP_WIDTH
);
  logic ceb1;
  logic cem;
  logic in_valid;
  logic [1:0] opmode;
  logic signed [WIDTH-1:0] d0;
  logic signed [WIDTH-1:0] b0;
  logic signed [WIDTH-1:0] a1;
  logic signed [WIDTH-1:0] bcout;
  logic signed [2*WIDTH-1:0] m;
  logic m_valid;
  modport master (output ceb1, cem, in_valid, opmode, d0, b0, a1, input bcout, m, m_valid);
  modport slave (input ceb1, cem, in_valid, opmode, d0, b0, a1, output bcout, m, m_valid);
endinterface

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: optional enabled pipeline register with async active-low clear.
// Ports: clk, rst (active low, async), ce (load enable), d (input), q (REG=1: registered d, REG=0: d).
module dsp_pipe_reg #(
  parameter bit REG = 1'b1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (REG) begin : g_reg
    logic [W-1:0] r;
    always_ff @(posedge clk or negedge rst)
      if (!rst) r <= '0;
      else if (ce) r <= d;
    assign q = r;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end
endmodule

// File: rtl/dsp_preadd_mult_stage.sv
// dsp_preadd_mult_stage: D +/- B pre-adder, optional B1 register, 18x18 signed multiply, optional M register.
// Ports: clk, rst (async active low), bus (slave: ceb1, cem, in_valid, opmode, d0, b0, a1 in; bcout, m, m_valid out).
module dsp_preadd_mult_stage
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH = DSP_WIDTH,
  parameter bit B1REG = 1'b1,
  parameter bit MREG = 1'b1
) (
  input logic clk,
  input logic rst,
  dsp_preadd_mult_stage_if.slave bus
);
  logic signed [WIDTH-1:0] pre;
  logic signed [WIDTH-1:0] b1;
  logic [WIDTH:0] b1_q;
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0] m_q;
  // the sum wraps to WIDTH bits; the subtract bit only matters when the pre-adder is enabled
  always_comb pre = !bus.opmode[OP_EN] ? bus.b0 : bus.opmode[OP_SUB] ? bus.d0 - bus.b0 : bus.d0 + bus.b0;
  dsp_pipe_reg #(.REG(B1REG), .W(WIDTH + 1)) u_b1 (
    .clk(clk),
    .rst(rst),
    .ce(bus.ceb1),
    .d({bus.in_valid, pre}),
    .q(b1_q)
  );
  assign b1 = b1_q[WIDTH-1:0];
  // a1 is already time-aligned with b1 upstream, so it is used undelayed
  always_comb prod = (2*WIDTH)'(b1) * (2*WIDTH)'(bus.a1);
  dsp_pipe_reg #(.REG(MREG), .W(2*WIDTH + 1)) u_m (
    .clk(clk),
    .rst(rst),
    .ce(bus.cem),
    .d({b1_q[WIDTH], prod}),
    .q(m_q)
  );
  assign bus.bcout = b1;
  assign bus.m = m_q[2*WIDTH-1:0];
  assign bus.m_valid = m_q[2*WIDTH];
endmodule

// File: tb/tb_dsp_preadd_mult_stage.sv
// tb_dsp_preadd_mult_stage: directed checks on all four B1REG/MREG builds plus a scoreboard on the fully registered build.
module tb_dsp_preadd_mult_stage;
  import dsp48a1_pkg::*;
  localparam int W = DSP_WIDTH;
  localparam longint FS = 64'sd17179869184;
  logic clk = 1'b0;
  logic rst;
  logic ceb1;
  logic cem;
  logic in_valid;
  logic [1:0] opmode;
  logic signed [W-1:0] d0;
  logic signed [W-1:0] b0;
  logic signed [W-1:0] a1;
  logic signed [DSP_PROD_W-1:0] m_v [4];
  logic signed [W-1:0] bc_v [4];
  logic [3:0] mv;
  logic signed [DSP_PROD_W-1:0] exp_q [$];
  logic sb_cap;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // index g = 2*B1REG + MREG: 0 fully combinational, 3 fully registered
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dsp_preadd_mult_stage_if #(.WIDTH(W)) bus ();
    assign bus.ceb1 = ceb1;
    assign bus.cem = cem;
    assign bus.in_valid = in_valid;
    assign bus.opmode = opmode;
    assign bus.d0 = d0;
    assign bus.b0 = b0;
    assign bus.a1 = a1;
    assign m_v[g] = bus.m;
    assign bc_v[g] = bus.bcout;
    assign mv[g] = bus.m_valid;
    dsp_preadd_mult_stage #(.WIDTH(W), .B1REG(g / 2 == 1), .MREG(g % 2 == 1)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // reference: pre-add in wide arithmetic, wrap to W bits, then full-precision product
  function automatic logic signed [DSP_PROD_W-1:0] model(input logic [1:0] op, input logic signed [W-1:0] d, input logic signed [W-1:0] b, input logic signed [W-1:0] a);
    longint wide;
    logic signed [W-1:0] p;
    wide = !op[0] ? longint'(b) : op[1] ? longint'(d) - longint'(b) : longint'(d) + longint'(b);
    p = W'(wide);
    return DSP_PROD_W'(longint'(p) * longint'(a));
  endfunction
  task automatic tick();
    @(negedge clk);
  endtask
  always @(negedge rst) exp_q.delete();
  // a sample is booked when B1 captures it; a1 is held until M captures it, so the product is known then
  always @(posedge clk) begin
    if (rst && ceb1 && in_valid) exp_q.push_back(model(opmode, d0, b0, a1));
    sb_cap = rst && cem;
    #1;
    if (sb_cap && mv[3]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed m_valid=1 with empty queue, expected no output");
      end else chk("sb_m", m_v[3], exp_q.pop_front());
    end
  end
  initial begin
    rst = 1'b1;
    ceb1 = 1'b1;
    cem = 1'b1;
    in_valid = 1'b1;
    opmode = 2'b01;
    d0 = 5;
    b0 = 3;
    a1 = -2;
    #7;
    rst = 1'b0;
    #1;
    chk("rst_bcout", bc_v[3], 0);
    chk("rst_m", m_v[3], 0);
    chk("rst_mvalid", mv[3], 0);
    chk("rst_mvalid_01", mv[1], 0);
    chk("rst_mvalid_10", mv[2], 0);
    tick();
    tick();
    chk("rst_hold_bcout", bc_v[3], 0);
    chk("rst_hold_mvalid", mv[3], 0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("no_stale_valid", mv[3], 0);
    in_valid = 1'b1;
    opmode = 2'b01;
    d0 = 5;
    b0 = 3;
    a1 = -2;
    #1;
    chk("comb_add_m", m_v[0], -16);
    chk("comb_add_valid", mv[0], 1);
    tick();
    chk("add_bcout", bc_v[3], 8);
    chk("add_latency", mv[3], 0);
    in_valid = 1'b0;
    tick();
    chk("add_m", m_v[3], -16);
    chk("add_mvalid", mv[3], 1);
    in_valid = 1'b1;
    opmode = 2'b11;
    d0 = -131072;
    b0 = 1;
    a1 = 2;
    tick();
    chk("sub_wrap_bcout", bc_v[3], 131071);
    in_valid = 1'b0;
    tick();
    chk("sub_wrap_m", m_v[3], 262142);
    in_valid = 1'b1;
    opmode = 2'b10;
    d0 = 100;
    b0 = -7;
    a1 = -7;
    #1;
    chk("comb_bypass_bcout", bc_v[0], -7);
    tick();
    chk("bypass_bcout", bc_v[3], -7);
    in_valid = 1'b0;
    tick();
    chk("bypass_m", m_v[3], 49);
    opmode = 2'b01;
    a1 = 3;
    in_valid = 1'b1;
    d0 = 1;
    b0 = 2;
    tick();
    d0 = 10;
    b0 = 20;
    tick();
    d0 = 100;
    b0 = 200;
    ceb1 = 1'b0;
    cem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_m", m_v[3], 9);
      chk("stall_mvalid", mv[3], 1);
      chk("stall_bcout", bc_v[3], 30);
    end
    ceb1 = 1'b1;
    cem = 1'b1;
    tick();
    chk("stall_resume_m", m_v[3], 90);
    d0 = -5;
    b0 = 7;
    tick();
    d0 = 0;
    b0 = -9;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    opmode = 2'b00;
    d0 = 0;
    b0 = -131072;
    a1 = -131072;
    in_valid = 1'b1;
    #1;
    chk("lat0_valid", mv[0], 1);
    chk("lat0_m_fullscale", m_v[0], FS);
    chk("lat0_01_idle", mv[1], 0);
    chk("lat0_10_idle", mv[2], 0);
    chk("lat0_11_idle", mv[3], 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("lat1_00_idle", mv[0], 0);
    chk("lat1_01_valid", mv[1], 1);
    chk("lat1_01_m", m_v[1], FS);
    chk("lat1_10_valid", mv[2], 1);
    chk("lat1_10_m", m_v[2], FS);
    chk("lat1_11_idle", mv[3], 0);
    tick();
    chk("lat2_01_idle", mv[1], 0);
    chk("lat2_10_idle", mv[2], 0);
    chk("lat2_11_valid", mv[3], 1);
    chk("lat2_11_m", m_v[3], FS);
    tick();
    tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
